ram_scan_reader: RTL and testbench

Read-side controller for the 32x8 single-port synchronous RAM on the Lab5 memory board.
- Sweeps RAM addresses 0..31 at a programmable step rate, one read per step.
- Issues each read and tolerates the RAM's fixed read latency.
- Yields the port to the switch-driven writer whenever it is busy.
- Latches the address/data pair for the HEX display path.
- Complements the switch writer: the writer owns the port when busy, and this block owns it otherwise.

---
 rtl/ram_scan_reader.sv | 113 +++++++++++
 tb/tb_ram_scan_reader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_scan_reader.sv
// ram_scan_reader: sweeps the RAM one read per step event, yielding the port to the writer,
// and latches each completed address/data pair for the display path.
module ram_scan_reader #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1,
    parameter int STEP_CYCLES  = 25000000
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              hold,
    input  logic              step,
    input  logic              wr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              wrap
);
    localparam int PW = $clog2(STEP_CYCLES);
    localparam int LW = $clog2(READ_LATENCY + 1);
    localparam logic [PW-1:0] P_LAST = PW'(STEP_CYCLES - 1);
    localparam logic [LW-1:0] LAT = LW'(READ_LATENCY);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [ADDR_W-1:0] scan_addr_q, scan_addr_d, disp_addr_q, disp_addr_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              step_prev_q, step_prev_d, pending_q, pending_d;
    logic              disp_valid_q, disp_valid_d, wrap_q, wrap_d, ev;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            lat_q        <= '0;
            scan_addr_q  <= '0;
            disp_addr_q  <= '0;
            disp_data_q  <= '0;
            step_prev_q  <= 1'b1;
            pending_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            lat_q        <= lat_d;
            scan_addr_q  <= scan_addr_d;
            disp_addr_q  <= disp_addr_d;
            disp_data_q  <= disp_data_d;
            step_prev_q  <= step_prev_d;
            pending_q    <= pending_d;
            disp_valid_q <= disp_valid_d;
            wrap_q       <= wrap_d;
        end
    end

    always_comb begin
        ev           = hold ? (step & ~step_prev_q) : (presc_q == P_LAST);
        presc_d      = (hold || presc_q == P_LAST) ? '0 : presc_q + 1'b1;
        step_prev_d  = step;
        pending_d    = pending_q | (ev & (state_q != IDLE));
        state_d      = state_q;
        lat_d        = lat_q;
        scan_addr_d  = scan_addr_q;
        disp_addr_d  = disp_addr_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        wrap_d       = 1'b0;
        ram_rden     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ev || pending_q) begin
                    state_d   = ISSUE;
                    pending_d = 1'b0;
                end
            end
            ISSUE: begin
                // strobe qualified by this cycle's wr_busy so the port is never shared
                if (!wr_busy) begin
                    ram_rden = 1'b1;
                    lat_d    = LAT;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (wr_busy) begin
                    state_d = ISSUE;
                end else begin
                    lat_d = lat_q - 1'b1;
                    if (lat_q == LW'(1)) begin
                        disp_data_d  = ram_q;
                        disp_addr_d  = scan_addr_q;
                        disp_valid_d = 1'b1;
                        wrap_d       = &scan_addr_q;
                        scan_addr_d  = scan_addr_q + 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_addr   = scan_addr_q;
    assign disp_addr  = disp_addr_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign wrap       = wrap_q;
endmodule

// File: tb/tb_ram_scan_reader.sv
// tb_ram_scan_reader: two readers (read latency 1 and 3) against RAM models, checked every
// cycle against a transaction-level model plus directed literal expectations.
module tb_ram_scan_reader;
    localparam int STEP = 4;
    typedef struct {int c; int a; int d;} rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hold[2], step[2], busy[2];
    logic [4:0] ram_addr[2], disp_addr[2];
    logic [7:0] ram_q[2], disp_data[2];
    logic       ram_rden[2], disp_valid[2], wrap[2];
    logic [7:0] pipe0;
    logic [7:0] pipe1[3];
    int         checks = 0, failures = 0, cyc = 0;
    int         rl_of[2] = '{1, 3};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ram_scan_reader #(.READ_LATENCY(1), .STEP_CYCLES(STEP)) u0 (
        .CLOCK_50(clk), .RESET_N(rst_n), .hold(hold[0]), .step(step[0]), .wr_busy(busy[0]),
        .ram_addr(ram_addr[0]), .ram_rden(ram_rden[0]), .ram_q(ram_q[0]),
        .disp_addr(disp_addr[0]), .disp_data(disp_data[0]), .disp_valid(disp_valid[0]), .wrap(wrap[0]));
    ram_scan_reader #(.READ_LATENCY(3), .STEP_CYCLES(STEP)) u1 (
        .CLOCK_50(clk), .RESET_N(rst_n), .hold(hold[1]), .step(step[1]), .wr_busy(busy[1]),
        .ram_addr(ram_addr[1]), .ram_rden(ram_rden[1]), .ram_q(ram_q[1]),
        .disp_addr(disp_addr[1]), .disp_data(disp_data[1]), .disp_valid(disp_valid[1]), .wrap(wrap[1]));

    // RAM content is mem[a] = a + 8'h10; cycles without a read return a poison value
    always @(posedge clk) begin
        pipe0    <= ram_rden[0] ? {3'b000, ram_addr[0]} + 8'h10 : 8'hEE;
        pipe1[0] <= ram_rden[1] ? {3'b000, ram_addr[1]} + 8'h10 : 8'hEE;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign ram_q[0] = pipe0;
    assign ram_q[1] = pipe1[2];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: phase -1 idle, 0 waiting to issue, n>=1 is the n-th cycle after issue
    int  m_presc[2], m_phase[2], m_scan[2], m_da[2], m_dd[2];
    bit  m_sprev[2], m_pend[2], m_dv[2], m_wrap[2], m_ev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_presc[i] = 0; m_phase[i] = -1; m_scan[i] = 0; m_da[i] = 0; m_dd[i] = 0;
                m_sprev[i] = 1; m_pend[i] = 0; m_dv[i] = 0; m_wrap[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_ev = hold[i] ? (step[i] && !m_sprev[i]) : (m_presc[i] == STEP - 1);
                m_presc[i] = hold[i] ? 0 : (m_presc[i] + 1) % STEP;
                m_sprev[i] = step[i];
                m_wrap[i] = 0;
                if (m_phase[i] < 0) begin
                    if (m_ev || m_pend[i]) begin m_phase[i] = 0; m_pend[i] = 0; end
                end else begin
                    if (m_ev) m_pend[i] = 1;
                    if (m_phase[i] == 0) begin
                        if (!busy[i]) m_phase[i] = 1;
                    end else if (busy[i]) m_phase[i] = 0;
                    else if (m_phase[i] == rl_of[i]) begin
                        m_da[i] = m_scan[i]; m_dd[i] = m_scan[i] + 16; m_dv[i] = 1;
                        m_wrap[i] = (m_scan[i] == 31);
                        m_scan[i] = (m_scan[i] + 1) % 32;
                        m_phase[i] = -1;
                    end else m_phase[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.ram_rden", i), int'(ram_rden[i]), int'(m_phase[i] == 0 && !busy[i]));
            chk($sformatf("u%0d.ram_addr", i), int'(ram_addr[i]), m_scan[i]);
            chk($sformatf("u%0d.disp_addr", i), int'(disp_addr[i]), m_da[i]);
            chk($sformatf("u%0d.disp_data", i), int'(disp_data[i]), m_dd[i]);
            chk($sformatf("u%0d.disp_valid", i), int'(disp_valid[i]), int'(m_dv[i]));
            chk($sformatf("u%0d.wrap", i), int'(wrap[i]), int'(m_wrap[i]));
        end
    end

    rec_t rd0[$], rd1[$], cap0[$], cap1[$];
    int   wr0[$];
    logic [12:0] pv0, pv1;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_rden[0]) rd0.push_back('{cyc, int'(ram_addr[0]), 0});
            if (ram_rden[1]) rd1.push_back('{cyc, int'(ram_addr[1]), 0});
            if (disp_valid[0] && {disp_addr[0], disp_data[0]} != pv0)
                cap0.push_back('{cyc, int'(disp_addr[0]), int'(disp_data[0])});
            if (disp_valid[1] && {disp_addr[1], disp_data[1]} != pv1)
                cap1.push_back('{cyc, int'(disp_addr[1]), int'(disp_data[1])});
            if (wrap[0]) wr0.push_back(cyc);
            pv0 = {disp_addr[0], disp_data[0]};
            pv1 = {disp_addr[1], disp_data[1]};
        end
    end

    task automatic clear_logs();
        rd0.delete(); rd1.delete(); cap0.delete(); cap1.delete(); wr0.delete();
    endtask
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int c0, e;
    bit seen;
    initial begin
        hold = '{1'b0, 1'b1}; step = '{1'b0, 1'b0}; busy = '{1'b0, 1'b0};
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        c0 = cyc;
        clear_logs();
        // auto scan and wrap on reader 0
        for (int k = 0; k < 300 && cap0.size() < 33; k++) @(negedge clk);
        chk("auto_caps_reached", int'(cap0.size() >= 33), 1);
        if (cap0.size() >= 33) begin
            chk("first_rden_cycle", rd0[0].c - c0, 4);
            chk("second_rden_cycle", rd0[1].c - c0, 8);
            chk("third_rden_cycle", rd0[2].c - c0, 12);
            chk("first_cap_cycle", cap0[0].c - c0, 6);
            chk("cap0_addr", cap0[0].a, 0);  chk("cap0_data", cap0[0].d, 'h10);
            chk("cap1_addr", cap0[1].a, 1);  chk("cap1_data", cap0[1].d, 'h11);
            chk("cap2_addr", cap0[2].a, 2);  chk("cap2_data", cap0[2].d, 'h12);
            chk("cap31_addr", cap0[31].a, 31);
            chk("wrap_count", wr0.size(), 1);
            if (wr0.size() == 1) chk("wrap_cycle", wr0[0], cap0[31].c);
            chk("after_wrap_addr", cap0[32].a, 0);
            chk("after_wrap_data", cap0[32].d, 'h10);
        end
        // writer busy from the event cycle for 5 cycles
        hold[0] = 1'b1;
        cycles(10);
        clear_logs();
        cycles(1); step[0] = 1'b1; busy[0] = 1'b1; e = cyc;
        cycles(5); busy[0] = 1'b0; step[0] = 1'b0;
        cycles(10);
        chk("busy_rden_count", rd0.size(), 1);
        chk("busy_cap_count", cap0.size(), 1);
        if (rd0.size() == 1 && cap0.size() == 1) begin
            chk("busy_rden_cycle", rd0[0].c - e, 5);
            chk("busy_cap_addr", cap0[0].a, rd0[0].a);
        end
        // writer busy during the wait cycle forces one retry
        clear_logs();
        cycles(1); step[0] = 1'b1; e = cyc;
        cycles(1); step[0] = 1'b0;
        cycles(1); busy[0] = 1'b1;
        cycles(1); busy[0] = 1'b0;
        cycles(10);
        chk("retry_rden_count", rd0.size(), 2);
        chk("retry_cap_count", cap0.size(), 1);
        if (rd0.size() == 2 && cap0.size() == 1) begin
            chk("retry_first_issue", rd0[0].c - e, 1);
            chk("retry_second_issue", rd0[1].c - e, 3);
            chk("retry_same_addr", rd0[1].a, rd0[0].a);
            chk("retry_cap_cycle", cap0[0].c - e, 5);
            chk("retry_cap_addr", cap0[0].a, rd0[0].a);
        end
        // step held high through reset, then three manual steps
        cycles(1); rst_n = 1'b0; step[0] = 1'b1;
        cycles(2);
        @(negedge clk); #1 rst_n = 1'b1;
        clear_logs();
        cycles(20);
        chk("held_step_no_read", rd0.size(), 0);
        step[0] = 1'b0;
        cycles(5);
        for (int k = 0; k < 3; k++) begin
            step[0] = 1'b1; cycles(2);
            step[0] = 1'b0; cycles(8);
        end
        chk("manual_rden_count", rd0.size(), 3);
        chk("manual_cap_count", cap0.size(), 3);
        if (cap0.size() == 3)
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("manual_addr%0d", k), cap0[k].a, k);
                chk($sformatf("manual_data%0d", k), cap0[k].d, 'h10 + k);
            end
        // reader 1: queued second event, third edge dropped
        clear_logs();
        cycles(1); step[1] = 1'b1; e = cyc;
        cycles(1); step[1] = 1'b0;
        cycles(1); step[1] = 1'b1;
        cycles(1); step[1] = 1'b0;
        cycles(1); step[1] = 1'b1;
        cycles(1); step[1] = 1'b0;
        cycles(20);
        chk("queued_rden_count", rd1.size(), 2);
        chk("queued_cap_count", cap1.size(), 2);
        if (rd1.size() == 2 && cap1.size() == 2) begin
            chk("queued_issue0", rd1[0].c - e, 1);
            chk("queued_issue1", rd1[1].c - e, 6);
            chk("queued_cap0_cycle", cap1[0].c - e, 5);
            chk("queued_cap0_addr", cap1[0].a, 0);
            chk("queued_cap0_data", cap1[0].d, 'h10);
            chk("queued_cap1_cycle", cap1[1].c - e, 10);
            chk("queued_cap1_addr", cap1[1].a, 1);
            chk("queued_cap1_data", cap1[1].d, 'h11);
        end
        // reader 1: reset while waiting for read data
        hold[1] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = ram_rden[1];
        end
        chk("midread_issue_seen", int'(seen), 1);
        @(posedge clk); #3 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rden", int'(ram_rden[1]), 0);
        chk("rst_ram_addr", int'(ram_addr[1]), 0);
        chk("rst_disp_addr", int'(disp_addr[1]), 0);
        chk("rst_disp_data", int'(disp_data[1]), 0);
        chk("rst_disp_valid", int'(disp_valid[1]), 0);
        chk("rst_wrap", int'(wrap[1]), 0);
        @(negedge clk); #1 rst_n = 1'b1;
        c0 = cyc;
        clear_logs();
        cycles(20);
        chk("restart_cap_seen", int'(cap1.size() >= 1), 1);
        if (cap1.size() >= 1) begin
            chk("restart_cap_cycle", cap1[0].c - c0, 8);
            chk("restart_cap_addr", cap1[0].a, 0);
            chk("restart_cap_data", cap1[0].d, 'h10);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
